key_mode_ctrl: RTL and testbench

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

---
 rtl/key_mode_ctrl.sv | 97 +++++++++
 tb/tb_key_mode_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounced push button; short press advances the LED mode, long press steps the LED group mask.
module key_mode_ctrl #(
    parameter int DEB_CYCLES  = 12,
    parameter int LONG_CYCLES = 600,
    parameter int NUM_MODES   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic [2:0] mode,
    output logic [7:0] led_select,
    output logic       mode_changed,
    output logic       long_press
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_RELEASE} state_t;
    state_t state;
    logic sync0, key_s, is_long, deb_done, hold_done;
    logic [DW-1:0] deb_cnt, deb_inc;
    logic [HW-1:0] hold_cnt, hold_inc;
    logic [2:0] mode_nxt;
    logic [7:0] led_nxt;
    // The cycle that first sees the new key level counts as the first stable cycle,
    // so the debounce state itself needs DEB_CYCLES-1 further stable cycles.
    always_comb begin
        deb_inc   = (deb_cnt == DW'(DEB_CYCLES)) ? deb_cnt : deb_cnt + 1'b1;
        deb_done  = deb_inc >= DW'(DEB_CYCLES - 1);
        hold_inc  = (hold_cnt == HW'(LONG_CYCLES)) ? hold_cnt : hold_cnt + 1'b1;
        hold_done = hold_inc >= HW'(LONG_CYCLES);
        mode_nxt  = (mode >= 3'(NUM_MODES - 1)) ? 3'd0 : mode + 3'd1;
        led_nxt   = (led_select == 8'hFF) ? 8'h01 :
                    ($onehot(led_select) && led_select != 8'h80) ? {led_select[6:0], 1'b0} : 8'hFF;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync0        <= 1'b1;
            key_s        <= 1'b1;
            is_long      <= 1'b0;
            deb_cnt      <= '0;
            hold_cnt     <= '0;
            mode         <= 3'd0;
            led_select   <= 8'hFF;
            mode_changed <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            sync0        <= key_n;
            key_s        <= sync0;
            mode_changed <= 1'b0;
            long_press   <= 1'b0;
            case (state)
                IDLE: if (!key_s) begin
                    state   <= DEB_PRESS;
                    deb_cnt <= '0;
                end
                DEB_PRESS: if (key_s) state <= IDLE;
                else begin
                    deb_cnt <= deb_inc;
                    if (deb_done) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                        is_long  <= 1'b0;
                    end
                end
                PRESSED: if (key_s) begin
                    state   <= DEB_RELEASE;
                    deb_cnt <= '0;
                end else begin
                    hold_cnt <= hold_inc;
                    if (hold_done) begin
                        state      <= LONG_HELD;
                        is_long    <= 1'b1;
                        long_press <= 1'b1;
                        led_select <= led_nxt;
                    end
                end
                LONG_HELD: if (key_s) begin
                    state   <= DEB_RELEASE;
                    deb_cnt <= '0;
                end
                DEB_RELEASE: if (!key_s) state <= is_long ? LONG_HELD : PRESSED;
                else begin
                    deb_cnt <= deb_inc;
                    if (deb_done) begin
                        state <= IDLE;
                        if (!is_long) begin
                            mode         <= mode_nxt;
                            mode_changed <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl: directed scenarios for the button debouncer and mode controller.
module tb_key_mode_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, key_n = 1'b1;
    logic [2:0] mode;
    logic [7:0] led_select;
    logic mode_changed, long_press;
    int pass_cnt = 0, total = 0, mc_cnt = 0, lp_cnt = 0, rule_bad = 0;
    logic prev_mc = 1'b0, prev_lp = 1'b0;

    key_mode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .mode(mode),
        .led_select(led_select), .mode_changed(mode_changed), .long_press(long_press)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mode_changed === 1'b1) mc_cnt++;
        if (long_press === 1'b1) lp_cnt++;
        if (mode_changed === 1'b1 && long_press === 1'b1) rule_bad++;
        if (mode_changed === 1'b1 && prev_mc === 1'b1) rule_bad++;
        if (long_press === 1'b1 && prev_lp === 1'b1) rule_bad++;
        prev_mc = mode_changed;
        prev_lp = long_press;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_key(input logic v, input int n);
        key_n = v;
        wait_n(n);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        key_n = 1'b1;
        rst_n = 1'b0;
        wait_n(3);
        total++; if (mode !== 3'd0) $display("FAIL reset_mode: got %0d want 0", mode); else pass_cnt++;
        total++; if (led_select !== 8'hFF) $display("FAIL reset_led: got %h want ff", led_select); else pass_cnt++;
        total++; if (mode_changed !== 1'b0 || long_press !== 1'b0) $display("FAIL reset_pulses: got %b%b want 00", mode_changed, long_press); else pass_cnt++;
        total++; if (3'(dut.state) !== 3'd0) $display("FAIL reset_state: got %0d want 0", 3'(dut.state)); else pass_cnt++;
        rst_n = 1'b1;
        wait_n(5);
        total++; if (mode !== 3'd0 || mc_cnt != 0 || lp_cnt != 0) $display("FAIL reset_idle: got mode %0d mc %0d lp %0d want 0 0 0", mode, mc_cnt, lp_cnt); else pass_cnt++;
    endtask

    task automatic test_clean_press;
        int m0, l0, first;
        m0 = mc_cnt; l0 = lp_cnt; first = 0;
        hold_key(1'b0, 50);
        total++; if (mc_cnt != m0) $display("FAIL clean_hold: got %0d pulses want 0", mc_cnt - m0); else pass_cnt++;
        key_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mode_changed === 1'b1 && first == 0) first = k;
        end
        total++; if (first != 14) $display("FAIL clean_latency: got %0d want 14", first); else pass_cnt++;
        total++; if (mc_cnt - m0 != 1) $display("FAIL clean_count: got %0d want 1", mc_cnt - m0); else pass_cnt++;
        total++; if (mode !== 3'd1) $display("FAIL clean_mode: got %0d want 1", mode); else pass_cnt++;
        total++; if (led_select !== 8'hFF || lp_cnt != l0) $display("FAIL clean_led: got %h lp %0d want ff 0", led_select, lp_cnt - l0); else pass_cnt++;
    endtask

    task automatic test_short_presses;
        logic [2:0] exp_mode [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        int m0, l0;
        do_reset;
        wait_n(2);
        m0 = mc_cnt; l0 = lp_cnt;
        for (int i = 0; i < 5; i++) begin
            hold_key(1'b0, 30);
            hold_key(1'b1, 30);
            total++; if (mode !== exp_mode[i]) $display("FAIL short_mode%0d: got %0d want %0d", i, mode, exp_mode[i]); else pass_cnt++;
        end
        total++; if (mc_cnt - m0 != 5 || lp_cnt != l0) $display("FAIL short_count: got mc %0d lp %0d want 5 0", mc_cnt - m0, lp_cnt - l0); else pass_cnt++;
    endtask

    task automatic test_long_press;
        int m0, l0, first;
        m0 = mc_cnt; l0 = lp_cnt; first = 0;
        key_n = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (long_press === 1'b1 && first == 0) first = k;
        end
        total++; if (first != 614) $display("FAIL long_latency: got %0d want 614", first); else pass_cnt++;
        total++; if (led_select !== 8'h01) $display("FAIL long_led: got %h want 01", led_select); else pass_cnt++;
        hold_key(1'b1, 30);
        total++; if (mode !== 3'd0) $display("FAIL long_mode: got %0d want 0", mode); else pass_cnt++;
        total++; if (mc_cnt != m0 || lp_cnt - l0 != 1) $display("FAIL long_count: got mc %0d lp %0d want 0 1", mc_cnt - m0, lp_cnt - l0); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int m0, l0;
        m0 = mc_cnt; l0 = lp_cnt;
        repeat (4) begin
            hold_key(1'b0, 5);
            hold_key(1'b1, 3);
        end
        hold_key(1'b0, 11);
        hold_key(1'b1, 30);
        total++; if (mc_cnt != m0 || lp_cnt != l0) $display("FAIL glitch_events: got mc %0d lp %0d want 0 0", mc_cnt - m0, lp_cnt - l0); else pass_cnt++;
        total++; if (3'(dut.state) !== 3'd0) $display("FAIL glitch_state: got %0d want 0", 3'(dut.state)); else pass_cnt++;
        total++; if (mode !== 3'd0 || led_select !== 8'h01) $display("FAIL glitch_outputs: got %0d %h want 0 01", mode, led_select); else pass_cnt++;
    endtask

    task automatic test_deb_boundary;
        int m0;
        m0 = mc_cnt;
        hold_key(1'b0, 12);
        hold_key(1'b1, 30);
        total++; if (mc_cnt - m0 != 1 || mode !== 3'd1) $display("FAIL deb_boundary: got mc %0d mode %0d want 1 1", mc_cnt - m0, mode); else pass_cnt++;
    endtask

    task automatic test_release_bounce;
        int m0;
        m0 = mc_cnt;
        hold_key(1'b0, 40);
        hold_key(1'b1, 4);
        hold_key(1'b0, 3);
        hold_key(1'b1, 20);
        wait_n(10);
        total++; if (mc_cnt - m0 != 1) $display("FAIL bounce_count: got %0d want 1", mc_cnt - m0); else pass_cnt++;
        total++; if (mode !== 3'd2) $display("FAIL bounce_mode: got %0d want 2", mode); else pass_cnt++;
    endtask

    task automatic test_led_sequence;
        logic [7:0] exp_led [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
        int m0, l0;
        do_reset;
        wait_n(2);
        m0 = mc_cnt; l0 = lp_cnt;
        for (int i = 0; i < 9; i++) begin
            hold_key(1'b0, 620);
            hold_key(1'b1, 20);
            total++; if (led_select !== exp_led[i]) $display("FAIL led_seq%0d: got %h want %h", i, led_select, exp_led[i]); else pass_cnt++;
        end
        total++; if (lp_cnt - l0 != 9 || mc_cnt != m0 || mode !== 3'd0) $display("FAIL led_count: got lp %0d mc %0d mode %0d want 9 0 0", lp_cnt - l0, mc_cnt - m0, mode); else pass_cnt++;
    endtask

    task automatic test_reset_mid_press;
        int m0, l0, first;
        hold_key(1'b0, 30);
        hold_key(1'b1, 30);
        hold_key(1'b0, 620);
        hold_key(1'b1, 20);
        total++; if (mode !== 3'd1 || led_select !== 8'h01) $display("FAIL mid_setup: got %0d %h want 1 01", mode, led_select); else pass_cnt++;
        key_n = 1'b0;
        wait_n(314);
        rst_n = 1'b0;
        wait_n(1);
        rst_n = 1'b1;
        total++; if (mode !== 3'd0 || led_select !== 8'hFF) $display("FAIL mid_reset: got %0d %h want 0 ff", mode, led_select); else pass_cnt++;
        m0 = mc_cnt; l0 = lp_cnt; first = 0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (long_press === 1'b1 && first == 0) first = k;
        end
        total++; if (first != 614) $display("FAIL mid_latency: got %0d want 614", first); else pass_cnt++;
        hold_key(1'b1, 30);
        total++; if (mc_cnt != m0 || lp_cnt - l0 != 1 || mode !== 3'd0 || led_select !== 8'h01) $display("FAIL mid_after: got mc %0d lp %0d mode %0d led %h want 0 1 0 01", mc_cnt - m0, lp_cnt - l0, mode, led_select); else pass_cnt++;
    endtask

    task automatic test_reset_priority;
        int l0;
        l0 = lp_cnt;
        key_n = 1'b0;
        wait_n(613);
        rst_n = 1'b0;
        wait_n(1);
        total++; if (long_press !== 1'b0 || led_select !== 8'hFF) $display("FAIL prio_reset: got lp %b led %h want 0 ff", long_press, led_select); else pass_cnt++;
        rst_n = 1'b1;
        key_n = 1'b1;
        wait_n(20);
        total++; if (lp_cnt != l0 || led_select !== 8'hFF) $display("FAIL prio_after: got lp %0d led %h want 0 ff", lp_cnt - l0, led_select); else pass_cnt++;
    endtask

    task automatic test_pulse_rules;
        total++; if (rule_bad != 0) $display("FAIL pulse_rules: got %0d violations want 0", rule_bad); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_short_presses;
        test_long_press;
        test_glitch;
        test_deb_boundary;
        test_release_bounce;
        test_led_sequence;
        test_reset_mid_press;
        test_reset_priority;
        test_pulse_rules;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
